// File: rtl/spi_reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_reg_pkg
//  Description : Shared types and constants for the SPI register controller.
//                Holds the transaction FSM state encoding and the position of
//                the read flag inside the command word.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_reg_pkg;

    // Transaction phases: waiting for a transfer, expecting the command word,
    // streaming write data, streaming read data.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_WR   = 2'd2,
        ST_RD   = 2'd3
    } state_e;

    // Read flag position counted down from the command word MSB (0 = MSB).
    // Everything below the flag is the start address.
    localparam int CMD_RD_BIT = 0;

endpackage : spi_reg_pkg
`default_nettype wire

// File: rtl/spi_reg_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : spi_reg_ctrl
//  Description : Bridges a word-oriented SPI slave to a simple register bus.
//                Word 0 of a transfer is a command {rd, addr}; every further
//                word is a data word with auto-incrementing address. Writes
//                strobe regWe per received word; reads strobe regRe per
//                shifter load and return the data on the following load.
//                Word 0 always returns the count of completed transactions.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_reg_ctrl
    import spi_reg_pkg::*;
#(
    parameter  int DATA_WDT = 8,
    localparam int ADDR_WDT = DATA_WDT - 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                spiStart,
    input  logic                spiEnd,
    input  logic                spiTxLoad,
    input  logic                spiRxRdy,
    input  logic [DATA_WDT-1:0] spiRxData,
    output logic [DATA_WDT-1:0] spiTxData,
    output logic [ADDR_WDT-1:0] regAddr,
    output logic                regWe,
    output logic [DATA_WDT-1:0] regWrData,
    output logic                regRe,
    input  logic [DATA_WDT-1:0] regRdData,
    output logic                txnDone
);

    // Bit index of the read flag inside a received command word.
    localparam int RD_POS = DATA_WDT - 1 - CMD_RD_BIT;

    state_e              state_q,       state_d;
    logic [ADDR_WDT-1:0] addr_reg_q,    addr_reg_d;
    logic [DATA_WDT-1:0] data_cnt_q,    data_cnt_d;
    logic [DATA_WDT-1:0] txn_cnt_q,     txn_cnt_d;
    logic [DATA_WDT-1:0] tx_data_q,     tx_data_d;
    logic [ADDR_WDT-1:0] reg_addr_q,    reg_addr_d;
    logic [DATA_WDT-1:0] reg_wr_data_q, reg_wr_data_d;
    logic                reg_we_q,      reg_we_d;
    logic                reg_re_q,      reg_re_d;
    logic                txn_done_q,    txn_done_d;
    logic                rd_pend_q,     rd_pend_d;

    // State and datapath registers; reset aborts any transfer immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            addr_reg_q    <= '0;
            data_cnt_q    <= '0;
            txn_cnt_q     <= '0;
            tx_data_q     <= '0;
            reg_addr_q    <= '0;
            reg_wr_data_q <= '0;
            reg_we_q      <= 1'b0;
            reg_re_q      <= 1'b0;
            txn_done_q    <= 1'b0;
            rd_pend_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_reg_q    <= addr_reg_d;
            data_cnt_q    <= data_cnt_d;
            txn_cnt_q     <= txn_cnt_d;
            tx_data_q     <= tx_data_d;
            reg_addr_q    <= reg_addr_d;
            reg_wr_data_q <= reg_wr_data_d;
            reg_we_q      <= reg_we_d;
            reg_re_q      <= reg_re_d;
            txn_done_q    <= txn_done_d;
            rd_pend_q     <= rd_pend_d;
        end
    end

    // Next-state and strobe generation. End of transfer has top priority so a
    // word arriving with it never produces a strobe; a start outside IDLE
    // restarts at the command word and drops the pending transaction.
    always_comb begin
        state_d       = state_q;
        addr_reg_d    = addr_reg_q;
        data_cnt_d    = data_cnt_q;
        txn_cnt_d     = txn_cnt_q;
        tx_data_d     = tx_data_q;
        reg_addr_d    = reg_addr_q;
        reg_wr_data_d = reg_wr_data_q;
        reg_we_d      = 1'b0;
        reg_re_d      = 1'b0;
        txn_done_d    = 1'b0;
        // Read data is valid on the bus one clock after the read strobe.
        rd_pend_d     = reg_re_q;

        if (spiEnd) begin
            state_d    = ST_IDLE;
            data_cnt_d = '0;
            if (data_cnt_q != '0) begin
                txn_done_d = 1'b1;
                txn_cnt_d  = txn_cnt_q + 1'b1;
            end
        end else if (spiStart) begin
            state_d    = ST_CMD;
            data_cnt_d = '0;
        end else begin
            case (state_q)
                ST_CMD: begin
                    if (spiRxRdy) begin
                        addr_reg_d = spiRxData[ADDR_WDT-1:0];
                        data_cnt_d = '0;
                        // Data phase keeps shifting the status word until a
                        // read returns real data.
                        tx_data_d  = txn_cnt_q;
                        state_d    = spiRxData[RD_POS] ? ST_RD : ST_WR;
                    end
                end
                ST_WR: begin
                    if (spiRxRdy) begin
                        reg_we_d      = 1'b1;
                        reg_addr_d    = addr_reg_q;
                        reg_wr_data_d = spiRxData;
                        addr_reg_d    = addr_reg_q + 1'b1;
                        data_cnt_d    = (data_cnt_q == '1) ? data_cnt_q : data_cnt_q + 1'b1;
                    end
                end
                ST_RD: begin
                    if (spiTxLoad) begin
                        reg_re_d   = 1'b1;
                        reg_addr_d = addr_reg_q;
                        addr_reg_d = addr_reg_q + 1'b1;
                        data_cnt_d = (data_cnt_q == '1) ? data_cnt_q : data_cnt_q + 1'b1;
                    end
                    if (rd_pend_q) begin
                        tx_data_d = regRdData;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Status count is presented whenever no data phase is active.
    assign spiTxData = ((state_q == ST_IDLE) || (state_q == ST_CMD)) ? txn_cnt_q : tx_data_q;
    assign regAddr   = reg_addr_q;
    assign regWe     = reg_we_q;
    assign regWrData = reg_wr_data_q;
    assign regRe     = reg_re_q;
    assign txnDone   = txn_done_q;

endmodule : spi_reg_ctrl
`default_nettype wire

// File: tb/tb_spi_reg_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_reg_ctrl
//  Description : Directed self-checking bench for spi_reg_ctrl (DATA_WDT=8).
//                A register model answers reads with addr+0x40.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_reg_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       spiStart, spiEnd, spiTxLoad, spiRxRdy;
    logic [7:0] spiRxData;
    logic [7:0] spiTxData;
    logic [6:0] regAddr;
    logic       regWe, regRe, txnDone;
    logic [7:0] regWrData;
    logic [7:0] regRdData = 8'h00;

    int n_assert = 0;
    int n_fail   = 0;

    logic [6:0] we_addr[$];
    logic [7:0] we_data[$];
    logic [6:0] re_addr[$];
    int         done_cnt = 0;
    int         both_cnt = 0;

    spi_reg_ctrl #(.DATA_WDT(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .spiStart  (spiStart),
        .spiEnd    (spiEnd),
        .spiTxLoad (spiTxLoad),
        .spiRxRdy  (spiRxRdy),
        .spiRxData (spiRxData),
        .spiTxData (spiTxData),
        .regAddr   (regAddr),
        .regWe     (regWe),
        .regWrData (regWrData),
        .regRe     (regRe),
        .regRdData (regRdData),
        .txnDone   (txnDone)
    );

    always #5 clk = ~clk;

    // Register model: read data valid the clock after regRe.
    always @(posedge clk) begin
        if (regRe) regRdData <= {1'b0, regAddr} + 8'h40;
    end

    // Strobe recorder, sampled just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (regWe) begin
            we_addr.push_back(regAddr);
            we_data.push_back(regWrData);
        end
        if (regRe) re_addr.push_back(regAddr);
        if (txnDone) done_cnt++;
        if (regWe && regRe) both_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_start();
        spiStart = 1'b1; @(negedge clk); spiStart = 1'b0; @(negedge clk);
    endtask

    task automatic do_end();
        spiEnd = 1'b1; @(negedge clk); spiEnd = 1'b0; @(negedge clk);
    endtask

    task automatic do_rx(input logic [7:0] w);
        spiRxData = w; spiRxRdy = 1'b1; @(negedge clk); spiRxRdy = 1'b0; @(negedge clk);
    endtask

    // Returns once any read data triggered by this load has reached spiTxData.
    task automatic do_load();
        spiTxLoad = 1'b1; @(negedge clk); spiTxLoad = 1'b0; @(negedge clk); @(negedge clk);
    endtask

    initial begin
        int wb, rb, db;
        reset = 1'b1; spiStart = 1'b0; spiEnd = 1'b0; spiTxLoad = 1'b0;
        spiRxRdy = 1'b0; spiRxData = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_txdata", spiTxData, 8'h00);
        chk("rst_addr",   regAddr,   7'h00);
        chk("rst_wdata",  regWrData, 8'h00);
        chk("rst_we",     regWe,     1'b0);
        chk("rst_re",     regRe,     1'b0);
        chk("rst_done",   txnDone,   1'b0);
        reset = 1'b0;
        @(negedge clk);

        // Write burst of three words from address 5.
        wb = we_addr.size(); db = done_cnt;
        do_start();
        chk("wr_word0_status", spiTxData, 8'h00);
        do_rx(8'h05); do_rx(8'h11); do_rx(8'h22); do_rx(8'h33);
        do_end();
        chk("wr_count", we_addr.size() - wb, 3);
        chk("wr_a0", we_addr[wb+0], 7'h05); chk("wr_d0", we_data[wb+0], 8'h11);
        chk("wr_a1", we_addr[wb+1], 7'h06); chk("wr_d1", we_data[wb+1], 8'h22);
        chk("wr_a2", we_addr[wb+2], 7'h07); chk("wr_d2", we_data[wb+2], 8'h33);
        chk("wr_done", done_cnt - db, 1);
        chk("wr_txncnt", spiTxData, 8'h01);

        // Read burst from 0x10; a received word during the read is ignored.
        wb = we_addr.size(); rb = re_addr.size();
        do_start();
        chk("rd_word0_status", spiTxData, 8'h01);
        do_rx(8'h90);
        do_load();
        chk("rd_tx0", spiTxData, 8'h50);
        do_rx(8'hAA);
        do_load();
        chk("rd_tx1", spiTxData, 8'h51);
        do_load();
        chk("rd_tx2", spiTxData, 8'h52);
        do_end();
        chk("rd_re_count", re_addr.size() - rb, 3);
        chk("rd_a0", re_addr[rb+0], 7'h10);
        chk("rd_a1", re_addr[rb+1], 7'h11);
        chk("rd_a2", re_addr[rb+2], 7'h12);
        chk("rd_no_we", we_addr.size() - wb, 0);
        chk("rd_txncnt", spiTxData, 8'h02);

        // Address wrap on write; a load during a write leaves spiTxData held.
        wb = we_addr.size(); rb = re_addr.size();
        do_start();
        do_rx(8'h7F); do_rx(8'hA1);
        do_load();
        chk("wrap_tx_hold", spiTxData, 8'h02);
        do_rx(8'hA2);
        do_end();
        chk("wrap_count", we_addr.size() - wb, 2);
        chk("wrap_a0", we_addr[wb+0], 7'h7F); chk("wrap_d0", we_data[wb+0], 8'hA1);
        chk("wrap_a1", we_addr[wb+1], 7'h00); chk("wrap_d1", we_data[wb+1], 8'hA2);
        chk("wrap_no_re", re_addr.size() - rb, 0);
        chk("wrap_txncnt", spiTxData, 8'h03);

        // Command-only read transfer: nothing strobed, nothing counted.
        rb = re_addr.size(); db = done_cnt;
        do_start(); do_rx(8'h85); do_end();
        chk("cmdonly_no_re", re_addr.size() - rb, 0);
        chk("cmdonly_no_done", done_cnt - db, 0);
        do_start();
        chk("cmdonly_next_status", spiTxData, 8'h03);

        // End in the same clock as the second data word of a write.
        wb = we_addr.size(); db = done_cnt;
        do_rx(8'h20); do_rx(8'h44);
        spiRxData = 8'h55; spiRxRdy = 1'b1; spiEnd = 1'b1;
        @(negedge clk);
        spiRxRdy = 1'b0; spiEnd = 1'b0;
        @(negedge clk);
        chk("abort_we_count", we_addr.size() - wb, 1);
        chk("abort_a0", we_addr[wb+0], 7'h20); chk("abort_d0", we_data[wb+0], 8'h44);
        chk("abort_done", done_cnt - db, 1);
        chk("abort_txncnt", spiTxData, 8'h04);
        do_rx(8'h66);
        chk("abort_idle_no_we", we_addr.size() - wb, 1);

        // Start without end: pending write is dropped without counting.
        db = done_cnt;
        do_start(); do_rx(8'h01); do_rx(8'h66);
        do_start();
        chk("restart_status", spiTxData, 8'h04);
        do_end();
        chk("restart_no_done", done_cnt - db, 0);

        // Reset between first and second data word of a read.
        do_start(); do_rx(8'h90);
        do_load();
        chk("rstmid_tx0", spiTxData, 8'h50);
        #2 reset = 1'b1;
        #1;
        chk("rstmid_txdata", spiTxData, 8'h00);
        chk("rstmid_addr",   regAddr,   7'h00);
        chk("rstmid_wdata",  regWrData, 8'h00);
        chk("rstmid_we",     regWe,     1'b0);
        chk("rstmid_re",     regRe,     1'b0);
        chk("rstmid_done",   txnDone,   1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        rb = re_addr.size();
        do_load(); do_rx(8'h91); do_load();
        chk("rstmid_no_re", re_addr.size() - rb, 0);
        do_start();
        chk("rstmid_status", spiTxData, 8'h00);
        do_rx(8'h83);
        do_load();
        chk("rstmid_resume_re", re_addr.size() - rb, 1);
        chk("rstmid_resume_a", re_addr[rb+0], 7'h03);
        chk("rstmid_resume_tx", spiTxData, 8'h43);
        do_end();
        chk("rstmid_resume_cnt", spiTxData, 8'h01);

        chk("we_re_exclusive", both_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Hard stop in case a wait never completes.
    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule : tb_spi_reg_ctrl
`default_nettype wire
